// File: rtl/xg_mem_pkg.sv
// Shared types and helpers for the data-memory controller: size codes, FSM states, lane masks, load extension.
// Latency: n/a (pure declarations and combinational functions).
// Backpressure: n/a.
// Contents: SZ_B/SZ_H/SZ_W/SZ_D, state_e, be_pair_t, byte_en(), load_ext().
package xg_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Byte-lane masks for the first and second beat of an access.
  typedef struct packed {
    logic [7:0] be1;
    logic [7:0] be0;
  } be_pair_t;

  // The access mask is built in a 16-lane window starting at the lane, then
  // cut at the word boundary (4 lanes when wide=0, 8 lanes when wide=1).
  // Anything that lands in be1 is the part that spills into the next word.
  function automatic be_pair_t byte_en(input logic [2:0] lane,
                                       input logic [1:0] size,
                                       input logic       wide);
    logic [15:0] m;
    be_pair_t    r;
    m = ((16'd1 << (4'd1 << size)) - 16'd1) << lane;
    if (wide) begin
      r.be0 = m[7:0];
      r.be1 = m[15:8];
    end else begin
      r.be0 = {4'b0000, m[3:0]};
      r.be1 = {4'b0000, m[7:4]};
    end
    return r;
  endfunction

  // bdata holds the accessed bytes packed from bit 0 upward (address order).
  function automatic logic [63:0] load_ext(input logic [63:0] bdata,
                                           input logic [1:0]  size,
                                           input logic        uns);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {{56{~uns & bdata[7]}},  bdata[7:0]};
      SZ_H:    r = {{48{~uns & bdata[15]}}, bdata[15:0]};
      SZ_W:    r = {{32{~uns & bdata[31]}}, bdata[31:0]};
      default: r = bdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: read data appears one cycle after an enabled access; writes land on the same edge.
// Backpressure: none; the controller owns all sequencing.
// Ports: clk_i; en_i access strobe; we_i write; be_i byte enables; addr_i word index;
//        wdata_i write data; rdata_o registered read data (old contents on a write).
module dmem_bank #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [XLEN/8-1:0]              be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [XLEN-1:0]                wdata_i,
  output logic [XLEN-1:0]                rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  // Storage is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        for (int b = 0; b < XLEN/8; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable little-endian data memory behind valid/ready request and response ports.
// Latency: response 2 cycles after acceptance, 3 when the access straddles a word boundary.
// Backpressure: one access in flight; req_ready only in IDLE, response held until rsp_ready.
// Ports: clk, rstn (async active-low); req_valid/req_ready/req_we/req_size/req_unsigned/
//        req_addr/req_wdata request side; rsp_valid/rsp_ready/rsp_rdata/rsp_err response side.
module dmem_ctrl
  import xg_mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int ADDR_W         = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH_WORDS * NB);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   lo_q, lo_d;      // first-beat read word of a split load

  // Geometry and fault decode from the latched request only, so nothing on
  // req_* reaches rsp_* combinationally.
  logic [2:0]      lane;
  be_pair_t        be;
  logic            split;
  logic [ADDR_W:0] last;
  logic            err;
  logic [AW-1:0]   word;

  assign lane  = 3'(addr_q[LB-1:0]);
  assign be    = byte_en(lane, size_q, NB == 8);
  assign split = |be.be1;
  // One extra bit so an access near the top of the address space cannot wrap.
  assign last  = {1'b0, addr_q} + (ADDR_W+1)'((4'd1 << size_q) - 4'd1);
  assign err   = ((size_q == SZ_D) && (NB == 4)) ||
                 (last >= MEM_BYTES) ||
                 (split && !ALLOW_MISALIGN);
  assign word  = addr_q[LB +: AW];

  // Store data positioned across a two-word window: low half is beat 0,
  // high half is what spills into word+1.
  logic [2*XLEN-1:0] wcat;
  assign wcat = {{XLEN{1'b0}}, wdata_q} << {lane, 3'b000};

  logic              bank_en, bank_we;
  logic [NB-1:0]     bank_be;
  logic [AW-1:0]     bank_addr;
  logic [XLEN-1:0]   bank_wdata, bank_rdata;

  dmem_bank #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk_i   (clk),
    .en_i    (bank_en),
    .we_i    (bank_we),
    .be_i    (bank_be),
    .addr_i  (bank_addr),
    .wdata_i (bank_wdata),
    .rdata_o (bank_rdata)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    bank_en    = 1'b0;
    bank_we    = 1'b0;
    bank_be    = '0;
    bank_addr  = word;
    bank_wdata = wcat[XLEN-1:0];
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_ACC0;
        end
      end
      ST_ACC0: begin
        // Faulting requests pass through here with the array untouched.
        bank_en = !err;
        bank_we = we_q;
        bank_be = be.be0[NB-1:0];
        state_d = (split && !err) ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        bank_en    = 1'b1;
        bank_we    = we_q;
        bank_be    = be.be1[NB-1:0];
        bank_addr  = word + AW'(1);
        bank_wdata = wcat[2*XLEN-1:XLEN];
        // Bank output still holds the ACC0 read; keep it before it is replaced.
        lo_d       = bank_rdata;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
    end
  end

  // Load assembly: line up the word(s) so the addressed byte sits at bit 0.
  // Array and lo_q are idle during RESP, so the result stays stable.
  logic [2*XLEN-1:0] rcat, rsh;
  logic [63:0]       ext;

  assign rcat = split ? {bank_rdata, lo_q} : {{XLEN{1'b0}}, bank_rdata};
  assign rsh  = rcat >> {lane, 3'b000};
  assign ext  = load_ext(64'(rsh[XLEN-1:0]), size_q, uns_q);

  assign rsp_rdata = (state_q == ST_RESP && !we_q && !err) ? ext[XLEN-1:0] : '0;
  assign rsp_err   = (state_q == ST_RESP) && err;

  // Bits above the live lanes are structurally present but carry nothing.
  logic unused_bits;
  assign unused_bits = ^{be, rsh, ext};

endmodule
